win_event_gen: RTL and testbench
================================

# win_event_gen

Window-event stimulus generator for the OVL window checkers (`ovl_win_unchange`, `ovl_window`, `ovl_win_change`). It is the driving end of the start_event / test_expr / end_event protocol those checkers consume. It accepts a command describing one window, then plays out a cycle-exact sequence of start pulse, hold period, end pulse and idle gap. It can optionally change test_expr inside the window, so one instance produces both pass and fail stimulus for the checker test suites.

## Interface
- WIDTH, 4, width of test_expr and cmd_value
- CNT_W, 8, width of the length fields and of win_count
- clk  in  1  sampling clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  generator can accept a command (state IDLE)
- cmd_value  in  WIDTH  test_expr value held across the window
- cmd_start_len  in  CNT_W  start_event high cycles; 0 is treated as 1
- cmd_hold_len  in  CNT_W  cycles between start and end phases; 0 allowed
- cmd_end_len  in  CNT_W  end_event high cycles; 0 is treated as 1
- cmd_gap_len  in  CNT_W  cycles after the end phase with test_expr=0; 0 allowed
- cmd_mutate  in  1  inject a change inside the window
- cmd_mut_idx  in  CNT_W  HOLD-cycle index (0-based) at which the mutation starts
- abort  in  1  synchronous abandon of the current window
- start_event  out  1  to checker start_event
- end_event  out  1  to checker end_event
- test_expr  out  WIDTH  to checker test_expr
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a window completes
- mutated  out  1  high from the first mutated cycle until the window is released
- win_count  out  CNT_W  count of completed windows; wraps

## Operation
- FSM states and transitions:
  - IDLE → START when cmd_valid && cmd_ready.
  - START (max(start_len,1) cycles) → HOLD (hold_len cycles; skipped if 0) → END (max(end_len,1) cycles) → GAP (gap_len cycles; skipped if 0) → IDLE.
- Command fields are latched on acceptance. Later changes to the cmd_* inputs have no effect on a running window.
- All outputs are registered.
- Outputs by state:
  - start_event = 1 only in START.
  - end_event = 1 only in END.
  - test_expr = latched value in START, HOLD and END; 0 in IDLE and GAP.
- Mutation:
  - Applies when cmd_mutate=1 and mut_idx < hold_len.
  - From HOLD cycle mut_idx through the last END cycle, test_expr = ~value.
  - mutated rises on that same cycle and clears on the return to IDLE.
  - If mut_idx ≥ hold_len, there is no mutation and mutated stays 0.
- done and win_count:
  - done = 1 for exactly the first cycle back in IDLE after a complete window.
  - win_count increments on that same edge, wrapping from 2^CNT_W−1 to 0.
- cmd_ready = 1 exactly when the state is IDLE, including the done cycle. This allows back-to-back windows.
- abort:
  - Sampled in any non-IDLE state.
  - Next edge: state IDLE, all event outputs 0, test_expr 0, mutated 0.
  - No done pulse; win_count unchanged.
  - Ignored in IDLE.
  - abort and acceptance in the same cycle is impossible, because acceptance happens only in IDLE.

## Timing
- Reset values: start_event 0, end_event 0, test_expr 0, busy 0, done 0, mutated 0, win_count 0, cmd_ready 1.
- rst asserted mid-window forces all outputs to their reset values immediately, asynchronously. No done pulse.
- Acceptance at edge N: start_event and busy are 1 from edge N+1.
- Window length from edge N+1 to IDLE:
  - S = max(start_len,1), H = hold_len, E = max(end_len,1), G = gap_len.
  - IDLE and done at edge N+1+S+H+E+G.
- A new command accepted in the done cycle produces start_event at the next edge. There is no dead cycle.
- Length counters compare against (len−1) in CNT_W bits. A length of 2^CNT_W−1 must work without overflow.

## Test plan
- WIDTH=4; value=4'b0101, start 2, hold 5, end 1, gap 3, no mutate:
  - start_event high cycles 1–2, test_expr 0101 cycles 1–8, end_event cycle 8.
  - done at cycle 12; win_count=1; checker silent.
- Same command with mutate=1, mut_idx=2:
  - test_expr 1010 from cycle 5 through 8; mutated=1 from cycle 5.
  - ovl_win_unchange fires.
- Zero lengths: start 0, hold 0, end 0, gap 0:
  - start_event cycle 1, end_event cycle 2, done cycle 3.
- Back-to-back: cmd_valid held high with two commands:
  - second start_event one edge after the first done; win_count=2.
- abort during HOLD:
  - next edge all outputs 0, busy 0, no done, win_count unchanged.
  - rst pulse during END: outputs 0 immediately, win_count 0.
- CNT_W=2: five windows complete:
  - win_count sequence 1,2,3,0,1.
  - mut_idx=3 with hold 3: mutated stays 0.

Source files
------------

// File: rtl/win_event_gen.sv
// rtl/win_event_gen.sv - start/hold/end/gap window stimulus generator for OVL window checkers
// Outputs are registered from next-state so start_event appears on the edge after acceptance.
module win_event_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic [CNT_W-1:0] cmd_start_len,
    input  logic [CNT_W-1:0] cmd_hold_len,
    input  logic [CNT_W-1:0] cmd_end_len,
    input  logic [CNT_W-1:0] cmd_gap_len,
    input  logic             cmd_mutate,
    input  logic [CNT_W-1:0] cmd_mut_idx,
    input  logic             abort,
    output logic             start_event,
    output logic             end_event,
    output logic [WIDTH-1:0] test_expr,
    output logic             busy,
    output logic             done,
    output logic             mutated,
    output logic [CNT_W-1:0] win_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_HOLD  = 3'd2,
        S_END   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] start_last_q, start_last_d;
    logic [CNT_W-1:0] hold_len_q, hold_len_d;
    logic [CNT_W-1:0] end_last_q, end_last_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] mut_idx_q, mut_idx_d;
    logic             mut_en_q, mut_en_d;
    logic             mut_act_q, mut_act_d;
    logic             done_d;

    logic             start_event_q, end_event_q, busy_q, done_q, cmd_ready_q;
    logic [WIDTH-1:0] test_expr_q;
    logic [CNT_W-1:0] win_count_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        value_d      = value_q;
        start_last_d = start_last_q;
        hold_len_d   = hold_len_q;
        end_last_d   = end_last_q;
        gap_len_d    = gap_len_q;
        mut_idx_d    = mut_idx_q;
        mut_en_d     = mut_en_q;
        mut_act_d    = mut_act_q;
        done_d       = 1'b0;

        // Length fields are stored as last-cycle indices so a length of 2^CNT_W-1 never overflows.
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d      = S_START;
                    cnt_d        = '0;
                    value_d      = cmd_value;
                    start_last_d = (cmd_start_len == '0) ? '0 : cmd_start_len - ONE;
                    hold_len_d   = cmd_hold_len;
                    end_last_d   = (cmd_end_len == '0) ? '0 : cmd_end_len - ONE;
                    gap_len_d    = cmd_gap_len;
                    mut_idx_d    = cmd_mut_idx;
                    mut_en_d     = cmd_mutate && (cmd_mut_idx < cmd_hold_len);
                end
            end
            S_START: begin
                if (cnt_q == start_last_q) begin
                    cnt_d   = '0;
                    state_d = (hold_len_q != '0) ? S_HOLD : S_END;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == hold_len_q - ONE) begin
                    cnt_d   = '0;
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_END: begin
                if (cnt_q == end_last_q) begin
                    cnt_d = '0;
                    if (gap_len_q != '0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == gap_len_q - ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        if (state_d == S_IDLE) begin
            mut_act_d = 1'b0;
        end else if (mut_en_d && state_d == S_HOLD && cnt_d == mut_idx_d) begin
            mut_act_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            value_q       <= '0;
            start_last_q  <= '0;
            hold_len_q    <= '0;
            end_last_q    <= '0;
            gap_len_q     <= '0;
            mut_idx_q     <= '0;
            mut_en_q      <= 1'b0;
            mut_act_q     <= 1'b0;
            start_event_q <= 1'b0;
            end_event_q   <= 1'b0;
            test_expr_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            win_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            start_last_q  <= start_last_d;
            hold_len_q    <= hold_len_d;
            end_last_q    <= end_last_d;
            gap_len_q     <= gap_len_d;
            mut_idx_q     <= mut_idx_d;
            mut_en_q      <= mut_en_d;
            mut_act_q     <= mut_act_d;
            start_event_q <= (state_d == S_START);
            end_event_q   <= (state_d == S_END);
            test_expr_q   <= (state_d == S_START || state_d == S_HOLD || state_d == S_END)
                             ? (mut_act_d ? ~value_d : value_d) : '0;
            busy_q        <= (state_d != S_IDLE);
            done_q        <= done_d;
            cmd_ready_q   <= (state_d == S_IDLE);
            win_count_q   <= win_count_q + CNT_W'(done_d);
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign start_event = start_event_q;
    assign end_event   = end_event_q;
    assign test_expr   = test_expr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mutated     = mut_act_q;
    assign win_count   = win_count_q;

endmodule

// File: tb/tb_win_event_gen.sv
// tb/tb_win_event_gen.sv - randomized bench for win_event_gen against a per-cycle frame-list model
// Directed windows pin literal cycle positions; random traffic is checked against the model every cycle.
module tb_win_event_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_value = '0;
    logic [7:0] cmd_start_len = '0, cmd_hold_len = '0, cmd_end_len = '0, cmd_gap_len = '0;
    logic       cmd_mutate = 1'b0;
    logic [7:0] cmd_mut_idx = '0;
    logic       abort = 1'b0;
    logic       start_event, end_event, busy, done, mutated;
    logic [3:0] test_expr;
    logic [7:0] win_count;

    int n_vec = 0;
    int n_err = 0;

    win_event_gen #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_value(cmd_value), .cmd_start_len(cmd_start_len), .cmd_hold_len(cmd_hold_len),
        .cmd_end_len(cmd_end_len), .cmd_gap_len(cmd_gap_len), .cmd_mutate(cmd_mutate),
        .cmd_mut_idx(cmd_mut_idx), .abort(abort), .start_event(start_event),
        .end_event(end_event), .test_expr(test_expr), .busy(busy), .done(done),
        .mutated(mutated), .win_count(win_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic       e;
        logic [3:0] tx;
        logic       busy;
        logic       mut;
        logic       done;
    } frame_t;

    frame_t     cur = '0;
    frame_t     pend[$];
    logic [7:0] m_count = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expand one command into the exact list of per-cycle outputs it must produce.
    function automatic void build(input logic [3:0] v, input int sl, input int hl, input int el,
                                  input int gl, input logic mu, input int mi);
        int     s_n;
        int     e_n;
        logic   men;
        frame_t f;
        s_n = (sl == 0) ? 1 : sl;
        e_n = (el == 0) ? 1 : el;
        men = mu && (mi < hl);
        for (int i = 0; i < s_n; i++) begin
            f = '0; f.s = 1'b1; f.tx = v; f.busy = 1'b1; pend.push_back(f);
        end
        for (int i = 0; i < hl; i++) begin
            f = '0; f.busy = 1'b1; f.mut = men && (i >= mi);
            f.tx = f.mut ? ~v : v; pend.push_back(f);
        end
        for (int i = 0; i < e_n; i++) begin
            f = '0; f.e = 1'b1; f.busy = 1'b1; f.mut = men;
            f.tx = men ? ~v : v; pend.push_back(f);
        end
        for (int i = 0; i < gl; i++) begin
            f = '0; f.busy = 1'b1; f.mut = men; pend.push_back(f);
        end
        f = '0; f.done = 1'b1; pend.push_back(f);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cur = '0;
                pend.delete();
                m_count = '0;
            end else begin
                if (cur.busy && abort) begin
                    pend.delete();
                    cur = '0;
                end else if (!cur.busy && cmd_valid) begin
                    build(cmd_value, int'(cmd_start_len), int'(cmd_hold_len), int'(cmd_end_len),
                          int'(cmd_gap_len), cmd_mutate, int'(cmd_mut_idx));
                    cur = pend.pop_front();
                end else if (pend.size() > 0) begin
                    cur = pend.pop_front();
                end else begin
                    cur = '0;
                end
                if (cur.done) m_count = m_count + 8'd1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("start_event", {7'd0, start_event}, {7'd0, cur.s});
            chk("end_event",   {7'd0, end_event},   {7'd0, cur.e});
            chk("test_expr",   {4'd0, test_expr},   {4'd0, cur.tx});
            chk("busy",        {7'd0, busy},        {7'd0, cur.busy});
            chk("cmd_ready",   {7'd0, cmd_ready},   {7'd0, ~cur.busy});
            chk("done",        {7'd0, done},        {7'd0, cur.done});
            chk("mutated",     {7'd0, mutated},     {7'd0, cur.mut});
            chk("win_count",   win_count,           m_count);
        end
    end

    logic       a_s[0:599], a_e[0:599], a_busy[0:599], a_mut[0:599], a_done[0:599];
    logic [3:0] a_tx[0:599];
    logic [7:0] a_cnt[0:599];

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("wait_idle_timeout", 8'd1, 8'd0);
    endtask

    // Cycle 0 is the negedge where the command is offered; cycle k is sampled k edges later.
    task automatic run_win(input logic [3:0] v, input logic [7:0] sl, input logic [7:0] hl,
                           input logic [7:0] el, input logic [7:0] gl, input logic mu,
                           input logic [7:0] mi, input int ncyc, input int abort_at,
                           input logic keep_valid);
        wait_idle();
        cmd_value = v; cmd_start_len = sl; cmd_hold_len = hl; cmd_end_len = el;
        cmd_gap_len = gl; cmd_mutate = mu; cmd_mut_idx = mi; abort = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            a_s[k] = start_event; a_e[k] = end_event; a_tx[k] = test_expr; a_busy[k] = busy;
            a_mut[k] = mutated; a_done[k] = done; a_cnt[k] = win_count;
            if (!keep_valid) begin
                cmd_valid = 1'b0;
                cmd_value = 4'($urandom);
                cmd_hold_len = 8'($urandom);
            end
            abort = (k == abort_at);
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        chk("reset_win_count", win_count, 8'd0);
        rst = 1'b0;

        run_win(4'b0101, 8'd2, 8'd5, 8'd1, 8'd3, 1'b0, 8'd0, 12, -1, 1'b0);
        chk("t1_start_c1", {7'd0, a_s[1]}, 8'd1);
        chk("t1_start_c2", {7'd0, a_s[2]}, 8'd1);
        chk("t1_start_c3", {7'd0, a_s[3]}, 8'd0);
        chk("t1_tx_c1", {4'd0, a_tx[1]}, 8'h5);
        chk("t1_tx_c8", {4'd0, a_tx[8]}, 8'h5);
        chk("t1_tx_c9", {4'd0, a_tx[9]}, 8'h0);
        chk("t1_end_c7", {7'd0, a_e[7]}, 8'd0);
        chk("t1_end_c8", {7'd0, a_e[8]}, 8'd1);
        chk("t1_done_c11", {7'd0, a_done[11]}, 8'd0);
        chk("t1_done_c12", {7'd0, a_done[12]}, 8'd1);
        chk("t1_count_c12", a_cnt[12], 8'd1);

        run_win(4'b0101, 8'd2, 8'd5, 8'd1, 8'd3, 1'b1, 8'd2, 12, -1, 1'b0);
        chk("t2_tx_c4", {4'd0, a_tx[4]}, 8'h5);
        chk("t2_tx_c5", {4'd0, a_tx[5]}, 8'hA);
        chk("t2_tx_c8", {4'd0, a_tx[8]}, 8'hA);
        chk("t2_mut_c4", {7'd0, a_mut[4]}, 8'd0);
        chk("t2_mut_c5", {7'd0, a_mut[5]}, 8'd1);
        chk("t2_mut_c11", {7'd0, a_mut[11]}, 8'd1);
        chk("t2_mut_c12", {7'd0, a_mut[12]}, 8'd0);
        chk("t2_count_c12", a_cnt[12], 8'd2);

        run_win(4'b1100, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 3, -1, 1'b0);
        chk("t3_start_c1", {7'd0, a_s[1]}, 8'd1);
        chk("t3_end_c2", {7'd0, a_e[2]}, 8'd1);
        chk("t3_done_c3", {7'd0, a_done[3]}, 8'd1);
        chk("t3_count_c3", a_cnt[3], 8'd3);

        run_win(4'b0011, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 6, -1, 1'b1);
        chk("b2b_done_c3", {7'd0, a_done[3]}, 8'd1);
        chk("b2b_count_c3", a_cnt[3], 8'd4);
        chk("b2b_start_c4", {7'd0, a_s[4]}, 8'd1);
        chk("b2b_done_c6", {7'd0, a_done[6]}, 8'd1);
        chk("b2b_count_c6", a_cnt[6], 8'd5);

        run_win(4'b0101, 8'd1, 8'd6, 8'd1, 8'd1, 1'b0, 8'd0, 5, 3, 1'b0);
        chk("abort_busy_c3", {7'd0, a_busy[3]}, 8'd1);
        chk("abort_busy_c4", {7'd0, a_busy[4]}, 8'd0);
        chk("abort_tx_c4", {4'd0, a_tx[4]}, 8'h0);
        chk("abort_done_c4", {7'd0, a_done[4]}, 8'd0);
        chk("abort_done_c5", {7'd0, a_done[5]}, 8'd0);
        chk("abort_count_c5", a_cnt[5], 8'd5);

        run_win(4'b0101, 8'd1, 8'd3, 8'd1, 8'd0, 1'b1, 8'd3, 6, -1, 1'b0);
        chk("midx_mut_c4", {7'd0, a_mut[4]}, 8'd0);
        chk("midx_mut_c5", {7'd0, a_mut[5]}, 8'd0);
        chk("midx_tx_c5", {4'd0, a_tx[5]}, 8'h5);
        chk("midx_count_c6", a_cnt[6], 8'd6);

        run_win(4'b0011, 8'd1, 8'd255, 8'd255, 8'd0, 1'b1, 8'd254, 512, -1, 1'b0);
        chk("big_mut_c255", {7'd0, a_mut[255]}, 8'd0);
        chk("big_mut_c256", {7'd0, a_mut[256]}, 8'd1);
        chk("big_tx_c256", {4'd0, a_tx[256]}, 8'hC);
        chk("big_end_c256", {7'd0, a_e[256]}, 8'd0);
        chk("big_end_c257", {7'd0, a_e[257]}, 8'd1);
        chk("big_end_c511", {7'd0, a_e[511]}, 8'd1);
        chk("big_done_c512", {7'd0, a_done[512]}, 8'd1);
        chk("big_count_c512", a_cnt[512], 8'd7);

        run_win(4'b0101, 8'd1, 8'd2, 8'd4, 8'd1, 1'b0, 8'd0, 4, -1, 1'b0);
        chk("rst_pre_end_c4", {7'd0, a_e[4]}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_end", {7'd0, end_event}, 8'd0);
        chk("rst_async_tx", {4'd0, test_expr}, 8'h0);
        chk("rst_async_busy", {7'd0, busy}, 8'd0);
        chk("rst_async_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_async_count", win_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        wait_idle();
        cmd_start_len = '0; cmd_hold_len = '0; cmd_end_len = '0; cmd_gap_len = '0;
        cmd_mutate = 1'b0; cmd_value = 4'b1001;
        cmd_valid = 1'b1;
        repeat (780) @(negedge clk);
        cmd_valid = 1'b0;
        chk("wrap_count_260", win_count, 8'd4);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            cmd_valid     = ($urandom_range(0, 3) == 0);
            cmd_value     = 4'($urandom);
            cmd_start_len = 8'($urandom_range(0, 4));
            cmd_hold_len  = 8'($urandom_range(0, 6));
            cmd_end_len   = 8'($urandom_range(0, 4));
            cmd_gap_len   = 8'($urandom_range(0, 4));
            cmd_mutate    = 1'($urandom);
            cmd_mut_idx   = 8'($urandom_range(0, 7));
            abort         = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
